control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that replaces the hand-sequenced per-instruction control benches.
- Decodes IR and drives dataPath strobes through fetch (T0–T2) and execute (T3–T7) for ld, ldi, st, R-type ALU, addi and halt.
- Memory read and write latency is parametrised through internal wait states.
- Sits between IR and the dataPath control inputs.

Parameters:
- OPC_W, 5: opcode width; opcode = ir[31:32-OPC_W].
- CTRL_W, 4: ALU control field width.
- MEM_LAT, 1: cycles the read or write strobe is held per memory access; must be ≥1.
- ALU_ADD, 2: ALU code for add.
- ALU_SUB, 3: ALU code for sub.
- ALU_AND, 4: ALU code for and.
- ALU_OR, 5: ALU code for or.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- ir  in  32  IR value from dataPath.
- PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPc  out  1 each  dataPath strobes.
- read, write  out  1 each  memory strobes.
- GRA, GRB, GRC, Rin, Rout, BAout, Cout  out  1 each  register-select and bus strobes.
- control  out  CTRL_W  ALU operation.
- mdr_read  out  2  MDR source: 00 = bus, 01 = memory.
- run  out  1  1 while executing, 0 once halted.
- step  out  4  current T-step 0–7; 15 when halted.

Behaviour:
- Moore FSM. State register and wait counter update on rising clk.
- All outputs decode combinationally from state only. Any strobe not listed for a step is 0. control = 0 except where stated.
- Reset (synchronous, active-high):
  - state → T0, wait counter → 0.
  - While reset is high, every output is forced 0, except step = 0 and run = 1.
  - Reset mid-instruction abandons the instruction; no partial strobes appear on the following cycle.
- Fetch:
  - T0: PCout, MARin, IncPc, Zlowin.
  - T1: Zlowout, PCin, read, MDRin, mdr_read = 01.
  - T1 wait (MEM_LAT−1 further cycles): read, MDRin, mdr_read = 01 only (PCin deasserted).
  - T2: MDRout, IRin.
- Decode at T2 → T3 from ir sampled that cycle; opcode is latched internally. Opcodes:
  - 0 = ld, 1 = ldi, 2 = st.
  - 3 = add, 4 = sub, 5 = and, 6 = or.
  - 7 = addi, 27 = halt.
  - Any other opcode is a nop: T2 → T0.
- ld:
  - T3: GRB, BAout, Yin.
  - T4: Cout, control = ALU_ADD, Zlowin.
  - T5: Zlowout, MARin.
  - T6: read, MDRin, mdr_read = 01, held for MEM_LAT cycles.
  - T7: MDRout, GRA, Rin. Then T0.
- ldi: T3 and T4 as ld; T5: Zlowout, GRA, Rin. Then T0.
- st:
  - T3–T5 as ld.
  - T6: GRA, Rout, MDRin, mdr_read = 00.
  - T7: write, held for MEM_LAT cycles. Then T0.
- R-type:
  - T3: GRB, Rout, Yin.
  - T4: GRC, Rout, Zlowin, control = op code (ALU_ADD/SUB/AND/OR).
  - T5: Zlowout, GRA, Rin. Then T0.
- addi:
  - T3: GRB, Rout, Yin.
  - T4: Cout, control = ALU_ADD, Zlowin.
  - T5: Zlowout, GRA, Rin. Then T0.
- halt: T3 enters HALT. In HALT: run = 0, step = 15, all strobes 0. Only reset exits.
- Wait counter:
  - Loads MEM_LAT−1 on entry to a memory step and decrements each cycle; the step advances when it reaches 0.
  - MEM_LAT = 1 gives no wait cycles.
- ir changes outside T2 have no effect.
- Cycle counts per instruction, counted T0 through the last step, with L = MEM_LAT:
  - ld: 6 + 2L.
  - st: 6 + 2L.
  - ldi, R-type, addi: 5 + L.
  - nop: 2 + L.

Test Plan:
- MEM_LAT = 1, ir = 0x00880023 (ld r0, 35(r1)) → T0..T7 in 8 cycles. T4: control = 2, Cout = 1. T7: MDRout = GRA = Rin = 1. Next cycle step = 0.
- MEM_LAT = 3, same ld → read high 3 consecutive cycles in T1 and 3 in T6. PCin high only in the first T1 cycle. Total 12 cycles.
- ir opcode 4 (sub) → T4: GRC = Rout = Zlowin = 1, control = 3. Return to T0 after T5 (6 cycles at MEM_LAT = 1).
- ir opcode 2 (st), MEM_LAT = 2 → T6: mdr_read = 00, GRA = Rout = MDRin = 1. write high exactly 2 cycles, read low throughout T6–T7.
- ir opcode 27 → run falls at T3 and step = 15. Strobes stay 0 for 20 cycles. Reset returns to step 0 with run = 1.
- Assert reset during ld T6 → next cycle all strobes 0. After release, fetch T0 strobes (PCout, MARin, IncPc, Zlowin) appear. Opcode 31 → nop, T2 → T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit: decodes IR and sequences dataPath strobes through
// fetch (T0-T2) and execute (T3-T7), with memory wait states set by MEM_LAT.
module control_sequencer #(
    parameter int OPC_W   = 5,
    parameter int CTRL_W  = 4,
    parameter int MEM_LAT = 1,
    parameter int ALU_ADD = 2,
    parameter int ALU_SUB = 3,
    parameter int ALU_AND = 4,
    parameter int ALU_OR  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ir,
    output logic              PCout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              MARin,
    output logic              Zlowin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              IncPc,
    output logic              read,
    output logic              write,
    output logic              GRA,
    output logic              GRB,
    output logic              GRC,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              Cout,
    output logic [CTRL_W-1:0] control,
    output logic [1:0]        mdr_read,
    output logic              run,
    output logic [3:0]        step
);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd15
    } state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] ir_opc;
    logic             is_mem;
    logic             is_rtype;
    logic             unused_ir;

    assign ir_opc    = ir[31 -: OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];
    assign is_mem    = (opc_q == OP_LD) || (opc_q == OP_LDI) || (opc_q == OP_ST);
    assign is_rtype  = (opc_q == OP_ADD) || (opc_q == OP_SUB) ||
                       (opc_q == OP_AND) || (opc_q == OP_OR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= T0;
            cnt   <= '0;
            opc_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == T2)
                opc_q <= ir_opc;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        Zlowin     = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        IncPc      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        GRA        = 1'b0;
        GRB        = 1'b0;
        GRC        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        BAout      = 1'b0;
        Cout       = 1'b0;
        control    = '0;
        mdr_read   = 2'b00;
        run        = 1'b1;
        step       = state;

        case (state)
            T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPc      = 1'b1;
                Zlowin     = 1'b1;
                state_next = T1;
                cnt_next   = CNT_LOAD;
            end
            T1: begin
                // PC writeback only on the first cycle of the fetch read
                read     = 1'b1;
                MDRin    = 1'b1;
                mdr_read = 2'b01;
                if (cnt == CNT_LOAD) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
                if (cnt == '0)
                    state_next = T2;
                else
                    cnt_next = cnt - CNT_W'(1);
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (ir_opc)
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_ADDI: state_next = T3;
                    OP_HALT:                state_next = HALT;
                    default:                state_next = T0;
                endcase
            end
            T3: begin
                GRB        = 1'b1;
                Yin        = 1'b1;
                BAout      = is_mem;
                Rout       = !is_mem;
                state_next = T4;
            end
            T4: begin
                Zlowin = 1'b1;
                if (is_rtype) begin
                    GRC  = 1'b1;
                    Rout = 1'b1;
                    case (opc_q)
                        OP_SUB:  control = CTRL_W'(ALU_SUB);
                        OP_AND:  control = CTRL_W'(ALU_AND);
                        OP_OR:   control = CTRL_W'(ALU_OR);
                        default: control = CTRL_W'(ALU_ADD);
                    endcase
                end else begin
                    Cout    = 1'b1;
                    control = CTRL_W'(ALU_ADD);
                end
                state_next = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if ((opc_q == OP_LD) || (opc_q == OP_ST)) begin
                    MARin      = 1'b1;
                    state_next = T6;
                    cnt_next   = CNT_LOAD;
                end else begin
                    GRA        = 1'b1;
                    Rin        = 1'b1;
                    state_next = T0;
                end
            end
            T6: begin
                MDRin = 1'b1;
                if (opc_q == OP_ST) begin
                    GRA        = 1'b1;
                    Rout       = 1'b1;
                    state_next = T7;
                    cnt_next   = CNT_LOAD;
                end else begin
                    read     = 1'b1;
                    mdr_read = 2'b01;
                    if (cnt == '0)
                        state_next = T7;
                    else
                        cnt_next = cnt - CNT_W'(1);
                end
            end
            T7: begin
                if (opc_q == OP_ST) begin
                    write = 1'b1;
                    if (cnt == '0)
                        state_next = T0;
                    else
                        cnt_next = cnt - CNT_W'(1);
                end else begin
                    MDRout     = 1'b1;
                    GRA        = 1'b1;
                    Rin        = 1'b1;
                    state_next = T0;
                end
            end
            HALT: begin
                run = 1'b0;
            end
            default: begin
                state_next = T0;
            end
        endcase

        // Reset masks everything so an abandoned instruction leaves no strobes
        if (reset) begin
            PCout    = 1'b0;
            Zlowout  = 1'b0;
            MDRout   = 1'b0;
            MARin    = 1'b0;
            Zlowin   = 1'b0;
            PCin     = 1'b0;
            MDRin    = 1'b0;
            IRin     = 1'b0;
            Yin      = 1'b0;
            IncPc    = 1'b0;
            read     = 1'b0;
            write    = 1'b0;
            GRA      = 1'b0;
            GRB      = 1'b0;
            GRC      = 1'b0;
            Rin      = 1'b0;
            Rout     = 1'b0;
            BAout    = 1'b0;
            Cout     = 1'b0;
            control  = '0;
            mdr_read = 2'b00;
            run      = 1'b1;
            step     = 4'd0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: three instances at MEM_LAT 1, 2 and 3
// share stimulus; each test checks one instance cycle by cycle.
module tb_control_sequencer;

    localparam logic [18:0] M_PCOUT   = 19'd1 << 18;
    localparam logic [18:0] M_ZLOWOUT = 19'd1 << 17;
    localparam logic [18:0] M_MDROUT  = 19'd1 << 16;
    localparam logic [18:0] M_MARIN   = 19'd1 << 15;
    localparam logic [18:0] M_ZLOWIN  = 19'd1 << 14;
    localparam logic [18:0] M_PCIN    = 19'd1 << 13;
    localparam logic [18:0] M_MDRIN   = 19'd1 << 12;
    localparam logic [18:0] M_IRIN    = 19'd1 << 11;
    localparam logic [18:0] M_YIN     = 19'd1 << 10;
    localparam logic [18:0] M_INCPC   = 19'd1 << 9;
    localparam logic [18:0] M_READ    = 19'd1 << 8;
    localparam logic [18:0] M_WRITE   = 19'd1 << 7;
    localparam logic [18:0] M_GRA     = 19'd1 << 6;
    localparam logic [18:0] M_GRB     = 19'd1 << 5;
    localparam logic [18:0] M_GRC     = 19'd1 << 4;
    localparam logic [18:0] M_RIN     = 19'd1 << 3;
    localparam logic [18:0] M_ROUT    = 19'd1 << 2;
    localparam logic [18:0] M_BAOUT   = 19'd1 << 1;
    localparam logic [18:0] M_COUT    = 19'd1 << 0;

    // Expected vector layout: {run, step, control, mdr_read, strobes}
    function automatic logic [29:0] ev(input logic r, input logic [3:0] s,
                                       input logic [3:0] c, input logic [1:0] m,
                                       input logic [18:0] st);
        return {r, s, c, m, st};
    endfunction

    localparam logic [29:0] E_RST  = ev(1'b1, 4'd0, 4'd0, 2'b00, 19'd0);
    localparam logic [29:0] E_T0   = ev(1'b1, 4'd0, 4'd0, 2'b00, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN);
    localparam logic [29:0] E_T1   = ev(1'b1, 4'd1, 4'd0, 2'b01, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
    localparam logic [29:0] E_T1W  = ev(1'b1, 4'd1, 4'd0, 2'b01, M_READ | M_MDRIN);
    localparam logic [29:0] E_T2   = ev(1'b1, 4'd2, 4'd0, 2'b00, M_MDROUT | M_IRIN);
    localparam logic [29:0] E_MT3  = ev(1'b1, 4'd3, 4'd0, 2'b00, M_GRB | M_BAOUT | M_YIN);
    localparam logic [29:0] E_MT4  = ev(1'b1, 4'd4, 4'd2, 2'b00, M_COUT | M_ZLOWIN);
    localparam logic [29:0] E_MT5  = ev(1'b1, 4'd5, 4'd0, 2'b00, M_ZLOWOUT | M_MARIN);
    localparam logic [29:0] E_LDT6 = ev(1'b1, 4'd6, 4'd0, 2'b01, M_READ | M_MDRIN);
    localparam logic [29:0] E_LDT7 = ev(1'b1, 4'd7, 4'd0, 2'b00, M_MDROUT | M_GRA | M_RIN);
    localparam logic [29:0] E_HALT = ev(1'b0, 4'd15, 4'd0, 2'b00, 19'd0);

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;

    logic [2:0] PCout_v, Zlowout_v, MDRout_v, MARin_v, Zlowin_v, PCin_v, MDRin_v;
    logic [2:0] IRin_v, Yin_v, IncPc_v, read_v, write_v, GRA_v, GRB_v, GRC_v;
    logic [2:0] Rin_v, Rout_v, BAout_v, Cout_v, run_v;
    logic [2:0][3:0] control_v;
    logic [2:0][1:0] mdr_v;
    logic [2:0][3:0] step_v;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        control_sequencer #(.MEM_LAT(g + 1)) dut (
            .clk(clk), .reset(reset), .ir(ir),
            .PCout(PCout_v[g]), .Zlowout(Zlowout_v[g]), .MDRout(MDRout_v[g]),
            .MARin(MARin_v[g]), .Zlowin(Zlowin_v[g]), .PCin(PCin_v[g]),
            .MDRin(MDRin_v[g]), .IRin(IRin_v[g]), .Yin(Yin_v[g]), .IncPc(IncPc_v[g]),
            .read(read_v[g]), .write(write_v[g]), .GRA(GRA_v[g]), .GRB(GRB_v[g]),
            .GRC(GRC_v[g]), .Rin(Rin_v[g]), .Rout(Rout_v[g]), .BAout(BAout_v[g]),
            .Cout(Cout_v[g]), .control(control_v[g]), .mdr_read(mdr_v[g]),
            .run(run_v[g]), .step(step_v[g])
        );
    end

    function automatic logic [29:0] obs(input int g);
        return {run_v[g], step_v[g], control_v[g], mdr_v[g],
                PCout_v[g], Zlowout_v[g], MDRout_v[g], MARin_v[g], Zlowin_v[g],
                PCin_v[g], MDRin_v[g], IRin_v[g], Yin_v[g], IncPc_v[g], read_v[g],
                write_v[g], GRA_v[g], GRB_v[g], GRC_v[g], Rin_v[g], Rout_v[g],
                BAout_v[g], Cout_v[g]};
    endfunction

    task automatic start_instr(input logic [31:0] instr);
        reset = 1'b1;
        ir    = instr;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [29:0] got;
        reset = 1'b1;
        ir    = 32'h00880023;
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            got = obs(g);
            tests_run++;
            if (got !== E_RST) begin
                $display("[TB] FAIL reset_state lat%0d: got %h expected %h", g + 1, got, E_RST);
                tests_failed++;
            end
        end
    endtask

    task automatic test_ld();
        logic [29:0] exp_seq [9];
        logic [29:0] got;
        exp_seq = '{E_T0, E_T1, E_T2, E_MT3, E_MT4, E_MT5, E_LDT6, E_LDT7, E_T0};
        start_instr(32'h00880023);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            // ir changing after decode must not affect the running ld
            if (i == 4) ir = 32'h20000000;
            got = obs(0);
            tests_run++;
            if (got !== exp_seq[i]) begin
                $display("[TB] FAIL ld_lat1 cycle%0d: got %h expected %h", i, got, exp_seq[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_ld_wait();
        logic [29:0] exp_seq [13];
        logic [29:0] got;
        exp_seq = '{E_T0, E_T1, E_T1W, E_T1W, E_T2, E_MT3, E_MT4, E_MT5,
                    E_LDT6, E_LDT6, E_LDT6, E_LDT7, E_T0};
        start_instr(32'h00880023);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            got = obs(2);
            tests_run++;
            if (got !== exp_seq[i]) begin
                $display("[TB] FAIL ld_lat3 cycle%0d: got %h expected %h", i, got, exp_seq[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_rtype();
        logic [29:0] exp_seq [7];
        logic [29:0] got;
        exp_seq = '{E_T0, E_T1, E_T2,
                    ev(1'b1, 4'd3, 4'd0, 2'b00, M_GRB | M_ROUT | M_YIN),
                    ev(1'b1, 4'd4, 4'd3, 2'b00, M_GRC | M_ROUT | M_ZLOWIN),
                    ev(1'b1, 4'd5, 4'd0, 2'b00, M_ZLOWOUT | M_GRA | M_RIN),
                    E_T0};
        start_instr(32'h20C40000);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            got = obs(0);
            tests_run++;
            if (got !== exp_seq[i]) begin
                $display("[TB] FAIL sub_lat1 cycle%0d: got %h expected %h", i, got, exp_seq[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_st();
        logic [29:0] exp_seq [11];
        logic [29:0] got;
        exp_seq = '{E_T0, E_T1, E_T1W, E_T2, E_MT3, E_MT4, E_MT5,
                    ev(1'b1, 4'd6, 4'd0, 2'b00, M_GRA | M_ROUT | M_MDRIN),
                    ev(1'b1, 4'd7, 4'd0, 2'b00, M_WRITE),
                    ev(1'b1, 4'd7, 4'd0, 2'b00, M_WRITE),
                    E_T0};
        start_instr(32'h10880010);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            got = obs(1);
            tests_run++;
            if (got !== exp_seq[i]) begin
                $display("[TB] FAIL st_lat2 cycle%0d: got %h expected %h", i, got, exp_seq[i]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_halt();
        logic [29:0] exp_seq [3];
        logic [29:0] got;
        exp_seq = '{E_T0, E_T1, E_T2};
        start_instr(32'hD8000000);
        for (int i = 0; i < 23; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (i == 5) ir = 32'h00880023;
            got = obs(0);
            tests_run++;
            if (got !== ((i < 3) ? exp_seq[i] : E_HALT)) begin
                $display("[TB] FAIL halt cycle%0d: got %h expected %h", i, got,
                         (i < 3) ? exp_seq[i] : E_HALT);
                tests_failed++;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        got = obs(0);
        tests_run++;
        if (got !== E_RST) begin
            $display("[TB] FAIL halt_reset: got %h expected %h", got, E_RST);
            tests_failed++;
        end
        reset = 1'b0;
        #1;
        got = obs(0);
        tests_run++;
        if (got !== E_T0) begin
            $display("[TB] FAIL halt_restart: got %h expected %h", got, E_T0);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_and_nop();
        logic [29:0] ld_seq [7];
        logic [29:0] nop_seq [4];
        logic [29:0] got;
        ld_seq  = '{E_T0, E_T1, E_T2, E_MT3, E_MT4, E_MT5, E_LDT6};
        nop_seq = '{E_T0, E_T1, E_T2, E_T0};
        start_instr(32'h00880023);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            got = obs(0);
            tests_run++;
            if (got !== ld_seq[i]) begin
                $display("[TB] FAIL midreset_ld cycle%0d: got %h expected %h", i, got, ld_seq[i]);
                tests_failed++;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        got = obs(0);
        tests_run++;
        if (got !== E_RST) begin
            $display("[TB] FAIL midreset_clear: got %h expected %h", got, E_RST);
            tests_failed++;
        end
        ir    = 32'hF8000000;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            got = obs(0);
            tests_run++;
            if (got !== nop_seq[i]) begin
                $display("[TB] FAIL nop cycle%0d: got %h expected %h", i, got, nop_seq[i]);
                tests_failed++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ir    = 32'h0;
        test_reset();
        test_ld();
        test_ld_wait();
        test_rtype();
        test_st();
        test_halt();
        test_reset_mid_and_nop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
